// File: rtl/sobel_stats_pkg.sv
// Shared types, default widths and the saturating-increment helper for the
// sobel output-stream statistics monitor.
package sobel_stats_pkg;

    typedef enum logic {SYNC, FRAME} stats_state_t;

    localparam int COLORDEPTH_DEF = 8;
    localparam int HV_W_DEF       = 12;
    localparam int EDGE_W_DEF     = 22;
    localparam int FRAME_W        = 16;

    // Counter of 'width' bits: add one unless already all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] top;
        top = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (val >= top) ? top : val + 32'd1;
    endfunction

endpackage

// File: rtl/sobel_frame_stats_if.sv
// Pixel stream from the sobel core plus the per-frame summary produced by the monitor.
interface sobel_frame_stats_if #(
    parameter int COLORDEPTH = 8,
    parameter int HV_W       = 12,
    parameter int EDGE_W     = 22
);
    import sobel_stats_pkg::*;

    logic [COLORDEPTH-1:0] red_i;
    logic [COLORDEPTH-1:0] green_i;
    logic [COLORDEPTH-1:0] blue_i;
    logic                  dv_i;
    logic                  hs_i;
    logic                  vs_i;
    logic [HV_W-1:0]       h_active_o;
    logic [HV_W-1:0]       v_active_o;
    logic [EDGE_W-1:0]     edge_cnt_o;
    logic [FRAME_W-1:0]    frame_cnt_o;
    logic                  stats_valid_o;
    logic                  err_o;

    modport master (
        output red_i, green_i, blue_i, dv_i, hs_i, vs_i,
        input  h_active_o, v_active_o, edge_cnt_o, frame_cnt_o, stats_valid_o, err_o
    );

    modport slave (
        input  red_i, green_i, blue_i, dv_i, hs_i, vs_i,
        output h_active_o, v_active_o, edge_cnt_o, frame_cnt_o, stats_valid_o, err_o
    );

endinterface

// File: rtl/sync_edge_det.sv
// Registered rise/fall detector; q is the delayed level aligned with rise/fall.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            q    <= d;
            rise <= d & ~q;
            fall <= ~d & q;
        end
    end

endmodule

// File: rtl/sobel_frame_stats.sv
// Monitor on the sobel output stream: per-frame line length, line count and
// edge-pixel count, with a sticky flag for broken line/frame timing.
module sobel_frame_stats
    import sobel_stats_pkg::*;
#(
    parameter int   COLORDEPTH = COLORDEPTH_DEF,
    parameter int   HV_W       = HV_W_DEF,
    parameter int   EDGE_W     = EDGE_W_DEF,
    parameter int   THRESHOLD  = 128,
    parameter logic VS_ACTIVE  = 1'b1
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 err_clr_i,
    sobel_frame_stats_if.slave   bus
);

    logic [COLORDEPTH-1:0] red_p0, green_p0, blue_p0, green_p1;
    logic                  dv_p0, hs_p0, vs_p0;
    logic                  dv_p1, dv_rise_p1, dv_fall_p1;
    logic                  vs_p1, vs_rise_p1, vs_fall_p1;
    logic                  is_edge_p1;
    logic                  err_set;
    logic                  unused_ok;

    stats_state_t          state;
    logic [HV_W-1:0]       pix_cnt, ref_len, line_cnt;
    logic [EDGE_W-1:0]     edge_acc;
    logic [HV_W-1:0]       h_active, v_active;
    logic [EDGE_W-1:0]     edge_cnt;
    logic [FRAME_W-1:0]    frame_cnt;
    logic                  stats_valid, err;

    // ---- stage p0: input registers ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dv_p0 <= 1'b0;
            hs_p0 <= 1'b0;
            vs_p0 <= 1'b0;
        end else begin
            dv_p0 <= bus.dv_i;
            hs_p0 <= bus.hs_i;
            vs_p0 <= (bus.vs_i == VS_ACTIVE);
        end
    end

    always_ff @(posedge clk) begin
        red_p0   <= bus.red_i;
        green_p0 <= bus.green_i;
        blue_p0  <= bus.blue_i;
        green_p1 <= green_p0;
    end

    // ---- stage p1: edge detection, aligned with green_p1 ----
    sync_edge_det u_dv_det (.clk(clk), .rst(rst), .d(dv_p0), .q(dv_p1), .rise(dv_rise_p1), .fall(dv_fall_p1));
    sync_edge_det u_vs_det (.clk(clk), .rst(rst), .d(vs_p0), .q(vs_p1), .rise(vs_rise_p1), .fall(vs_fall_p1));

    // Red/blue/hs are only held for debug probing.
    assign unused_ok  = ^{red_p0, blue_p0, hs_p0, dv_rise_p1, vs_p1, vs_fall_p1};
    assign is_edge_p1 = int'(green_p1) >= THRESHOLD;

    always_comb begin
        err_set = 1'b0;
        if (state == FRAME) begin
            if (vs_rise_p1)
                err_set = dv_p1 || (pix_cnt != '0);
            else if (dv_fall_p1 && (pix_cnt != '0) && (line_cnt != '0) && (pix_cnt != ref_len))
                err_set = 1'b1;
        end
    end

    // ---- stage p2: accumulate, latch summary ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SYNC;
            pix_cnt     <= '0;
            ref_len     <= '0;
            line_cnt    <= '0;
            edge_acc    <= '0;
            h_active    <= '0;
            v_active    <= '0;
            edge_cnt    <= '0;
            frame_cnt   <= '0;
            stats_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            stats_valid <= 1'b0;
            err         <= err_set | (err & ~err_clr_i);
            case (state)
                SYNC: begin
                    if (vs_rise_p1)
                        state <= FRAME;
                end
                FRAME: begin
                    if (vs_rise_p1) begin
                        h_active    <= ref_len;
                        v_active    <= line_cnt;
                        edge_cnt    <= edge_acc;
                        frame_cnt   <= frame_cnt + 16'd1;
                        stats_valid <= 1'b1;
                        pix_cnt     <= '0;
                        ref_len     <= '0;
                        line_cnt    <= '0;
                        edge_acc    <= '0;
                    end else begin
                        if (dv_p1)
                            pix_cnt <= HV_W'(sat_inc(32'(pix_cnt), HV_W));
                        if (dv_p1 && is_edge_p1)
                            edge_acc <= EDGE_W'(sat_inc(32'(edge_acc), EDGE_W));
                        // A fall with nothing counted is the tail of a pixel dropped at vs.
                        if (dv_fall_p1 && (pix_cnt != '0)) begin
                            line_cnt <= HV_W'(sat_inc(32'(line_cnt), HV_W));
                            if (line_cnt == '0)
                                ref_len <= pix_cnt;
                            pix_cnt <= '0;
                        end
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

    assign bus.h_active_o    = h_active;
    assign bus.v_active_o    = v_active;
    assign bus.edge_cnt_o    = edge_cnt;
    assign bus.frame_cnt_o   = frame_cnt;
    assign bus.stats_valid_o = stats_valid;
    assign bus.err_o         = err;

endmodule

// File: tb/tb_sobel_frame_stats.sv
// Directed bench for sobel_frame_stats: two instances share one stimulus stream,
// the second with a 4-bit edge counter to observe saturation.
module tb_sobel_frame_stats;

    logic clk;
    logic rst;
    logic err_clr;
    int   n_checks;
    int   n_fail;

    sobel_frame_stats_if                busa ();
    sobel_frame_stats_if #(.EDGE_W(4))  busb ();

    sobel_frame_stats u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .err_clr_i (err_clr),
        .bus       (busa)
    );

    sobel_frame_stats #(.EDGE_W(4)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .err_clr_i (err_clr),
        .bus       (busb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic [7:0] g, input logic vs);
        busa.dv_i = dv;  busa.green_i = g;  busa.vs_i = vs;
        busa.red_i = ~g; busa.blue_i = g;   busa.hs_i = 1'b0;
        busb.dv_i = dv;  busb.green_i = g;  busb.vs_i = vs;
        busb.red_i = ~g; busb.blue_i = g;   busb.hs_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // First n_edge pixels are 0xFF (edge), the rest 0x10; err_clr fires in gap slot clr_at.
    task automatic send_line(input int len, input int n_edge, input int clr_at);
        for (int i = 0; i < len; i++)
            drive(1'b1, (i < n_edge) ? 8'hFF : 8'h10, 1'b0);
        for (int g = 0; g < 4; g++) begin
            err_clr = (g == clr_at);
            drive(1'b0, 8'h00, 1'b0);
        end
        err_clr = 1'b0;
    endtask

    // vs goes active with optional coincident edge pixel; the pulse must land exactly 3 edges later.
    task automatic vs_edge(input logic dv_hit, input logic exp_pulse);
        drive(dv_hit, dv_hit ? 8'hFF : 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        check_eq("valid_early", 32'(busa.stats_valid_o), 32'd0);
        drive(1'b0, 8'h00, 1'b0);
        check_eq("valid_pulse", 32'(busa.stats_valid_o), 32'(exp_pulse));
        drive(1'b0, 8'h00, 1'b0);
        check_eq("valid_late", 32'(busa.stats_valid_o), 32'd0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_stats(input string tag, input int h, input int v, input int e,
                               input int eb, input int f, input logic er);
        check_eq({tag, "_h"},     32'(busa.h_active_o),  32'(h));
        check_eq({tag, "_v"},     32'(busa.v_active_o),  32'(v));
        check_eq({tag, "_edge"},  32'(busa.edge_cnt_o),  32'(e));
        check_eq({tag, "_edge4"}, 32'(busb.edge_cnt_o),  32'(eb));
        check_eq({tag, "_frame"}, 32'(busa.frame_cnt_o), 32'(f));
        check_eq({tag, "_err"},   32'(busa.err_o),       32'(er));
    endtask

    task automatic clear_err;
        err_clr = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        err_clr = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        err_clr  = 1'b0;
        rst      = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        check_stats("reset", 0, 0, 0, 0, 0, 1'b0);
        check_eq("reset_valid", 32'(busa.stats_valid_o), 32'd0);
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);

        // Partial frame before the first vs is discarded.
        send_line(8, 2, -1);
        vs_edge(1'b0, 1'b0);

        // 8x4 frame with 5 edge pixels.
        send_line(8, 2, -1);
        send_line(8, 3, -1);
        send_line(8, 0, -1);
        send_line(8, 0, -1);
        vs_edge(1'b0, 1'b1);
        check_stats("frame8x4", 8, 4, 5, 5, 1, 1'b0);

        // Line lengths 8,8,7,8.
        send_line(8, 0, -1);
        send_line(8, 0, -1);
        send_line(7, 0, -1);
        check_eq("err_len", 32'(busa.err_o), 32'd1);
        send_line(8, 0, -1);
        vs_edge(1'b0, 1'b1);
        check_stats("short_line", 8, 4, 0, 0, 2, 1'b1);
        clear_err();
        check_eq("err_clr", 32'(busa.err_o), 32'd0);

        // 20 edge pixels: 22-bit counter holds them, 4-bit counter saturates.
        for (int l = 0; l < 4; l++)
            send_line(8, 5, -1);
        vs_edge(1'b0, 1'b1);
        check_stats("sat", 8, 4, 20, 15, 3, 1'b0);

        // Edge pixel coincident with vs is dropped from both frames.
        send_line(8, 2, -1);
        send_line(8, 2, -1);
        vs_edge(1'b1, 1'b1);
        check_stats("coinc", 8, 2, 4, 4, 4, 1'b1);
        clear_err();
        check_eq("coinc_clr", 32'(busa.err_o), 32'd0);
        send_line(8, 1, -1);
        send_line(8, 1, -1);
        vs_edge(1'b0, 1'b1);
        check_stats("after_coinc", 8, 2, 2, 2, 5, 1'b0);

        // Frame with no lines still reports.
        vs_edge(1'b0, 1'b1);
        check_stats("empty", 0, 0, 0, 0, 6, 1'b0);

        // Clear in the same cycle as a length error: error wins.
        send_line(8, 0, -1);
        send_line(6, 0, 2);
        check_eq("set_wins", 32'(busa.err_o), 32'd1);
        drive(1'b0, 8'h00, 1'b0);
        check_eq("set_wins_hold", 32'(busa.err_o), 32'd1);

        // Reset mid-line clears outputs without waiting for a clock edge.
        drive(1'b1, 8'hFF, 1'b0);
        drive(1'b1, 8'hFF, 1'b0);
        rst = 1'b0;
        #1;
        check_stats("async_rst", 0, 0, 0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        send_line(5, 3, -1);
        vs_edge(1'b0, 1'b0);
        check_eq("rst_no_report", 32'(busa.frame_cnt_o), 32'd0);
        send_line(5, 1, -1);
        send_line(5, 1, -1);
        send_line(5, 1, -1);
        vs_edge(1'b0, 1'b1);
        check_stats("post_rst", 5, 3, 3, 3, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
